roach_reset_sequencer: RTL and testbench

Consumer side of the board clock infrastructure's lock/IDELAY handshake. Watches the MMCM lock, which is asynchronous to `sys_clk`, and filters it. It then drives the IDELAYCTRL reset pulse (`idelay_rst`), waits for `idelay_rdy`, and finally releases core and user resets in order. Sits directly after the clock infrastructure in every top level; all fabric resets derive from it.

---
 rtl/roach_rst_seq_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 29 ++
 rtl/roach_reset_sequencer.sv | 155 +++++++++++++++
 tb/tb_roach_reset_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/roach_rst_seq_pkg.sv
// Shared definitions for the reset sequencer: the sequencer state encoding,
// the width of the exported state field, and a small constant helper used
// to size the shared cycle counter.
package roach_rst_seq_pkg;

   localparam int SEQ_STATE_W = 3;

   typedef enum logic [SEQ_STATE_W-1:0] {
      WAIT_LOCK = 3'd0,
      IDLY_RST  = 3'd1,
      WAIT_RDY  = 3'd2,
      REL_CORE  = 3'd3,
      RUN       = 3'd4,
      FAULT     = 3'd5
   } seq_state_t;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk - destination clock
//   rst - synchronous active-high reset, both flops clear to 0
//   d   - asynchronous input level
//   q   - synchronized level, two clk edges behind d
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_reg;
   logic sync_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/roach_reset_sequencer.sv
// Board reset sequencer. Filters the MMCM lock, pulses the IDELAYCTRL reset,
// waits for IDELAYCTRL ready (retrying on timeout), then releases the core
// reset followed by the user reset. Lock loss restarts the whole sequence.
// Ports:
//   sys_clk, sys_rst   - clock and synchronous active-high reset
//   mmcm_lock          - MMCM LOCKED (asynchronous)
//   idelay_rdy         - IDELAYCTRL RDY (asynchronous)
//   idelay_rst         - IDELAYCTRL reset pulse
//   core_rst, user_rst - active-high fabric resets, released in that order
//   seq_done           - high while running
//   seq_fault          - retries exhausted; held until sys_rst
//   seq_state          - current state encoding
//   retry_count        - IDELAY retries in the current attempt
//   lock_loss_count    - saturating count of lock losses while running
module roach_reset_sequencer
   import roach_rst_seq_pkg::*;
#(
   parameter int LOCK_FILTER       = 1024,
   parameter int IDELAY_RST_CYCLES = 16,
   parameter int RDY_TIMEOUT       = 4096,
   parameter int MAX_RETRY         = 3,
   parameter int RELEASE_GAP       = 8
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic                   mmcm_lock,
   input  logic                   idelay_rdy,
   output logic                   idelay_rst,
   output logic                   core_rst,
   output logic                   user_rst,
   output logic                   seq_done,
   output logic                   seq_fault,
   output logic [SEQ_STATE_W-1:0] seq_state,
   output logic [3:0]             retry_count,
   output logic [7:0]             lock_loss_count
);

   localparam int CNT_MAX = max_of(max_of(LOCK_FILTER, IDELAY_RST_CYCLES),
                                   max_of(RDY_TIMEOUT, max_of(MAX_RETRY, RELEASE_GAP)));
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   logic             lock_s;
   logic             rdy_s;
   seq_state_t       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [3:0]       retry_reg, retry_next;
   logic [7:0]       loss_reg, loss_next;
   logic             idelay_rst_reg, core_rst_reg, user_rst_reg, seq_done_reg, seq_fault_reg;

   sync_2ff u_sync_lock (.clk(sys_clk), .rst(sys_rst), .d(mmcm_lock),  .q(lock_s));
   sync_2ff u_sync_rdy  (.clk(sys_clk), .rst(sys_rst), .d(idelay_rdy), .q(rdy_s));

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_reg      <= WAIT_LOCK;
         cnt_reg        <= '0;
         retry_reg      <= '0;
         loss_reg       <= '0;
         idelay_rst_reg <= 1'b0;
         core_rst_reg   <= 1'b1;
         user_rst_reg   <= 1'b1;
         seq_done_reg   <= 1'b0;
         seq_fault_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         retry_reg      <= retry_next;
         loss_reg       <= loss_next;
         // Outputs are decoded from the next state so they line up with seq_state.
         idelay_rst_reg <= (state_next == IDLY_RST);
         core_rst_reg   <= !((state_next == REL_CORE) || (state_next == RUN));
         user_rst_reg   <= (state_next != RUN);
         seq_done_reg   <= (state_next == RUN);
         seq_fault_reg  <= (state_next == FAULT);
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + 1'b1;
      retry_next = retry_reg;
      loss_next  = loss_reg;

      case (state_reg)
         WAIT_LOCK: begin
            if (!lock_s) begin
               cnt_next = '0;
            end else if (cnt_reg == CNT_W'(LOCK_FILTER - 1)) begin
               state_next = IDLY_RST;
               retry_next = '0;
            end
         end
         IDLY_RST: begin
            if (!lock_s) begin
               state_next = WAIT_LOCK;
            end else if (cnt_reg == CNT_W'(IDELAY_RST_CYCLES - 1)) begin
               state_next = WAIT_RDY;
            end
         end
         WAIT_RDY: begin
            // Ready is checked before the timeout so a coincident rdy wins.
            if (!lock_s) begin
               state_next = WAIT_LOCK;
            end else if (rdy_s) begin
               state_next = REL_CORE;
            end else if (cnt_reg == CNT_W'(RDY_TIMEOUT - 1)) begin
               if (retry_reg == 4'(MAX_RETRY)) begin
                  state_next = FAULT;
               end else begin
                  retry_next = retry_reg + 4'd1;
                  state_next = IDLY_RST;
               end
            end
         end
         REL_CORE: begin
            if (!lock_s) begin
               state_next = WAIT_LOCK;
            end else if (cnt_reg == CNT_W'(RELEASE_GAP - 1)) begin
               state_next = RUN;
            end
         end
         RUN: begin
            cnt_next = cnt_reg;
            if (!lock_s) begin
               state_next = WAIT_LOCK;
               if (loss_reg != 8'hFF) begin
                  loss_next = loss_reg + 8'd1;
               end
            end
         end
         FAULT: begin
            // Sticky: only sys_rst leaves this state.
            cnt_next = cnt_reg;
         end
         default: begin
            state_next = WAIT_LOCK;
         end
      endcase

      // The shared counter restarts from zero in every newly entered state.
      if (state_next != state_reg) begin
         cnt_next = '0;
      end
   end

   assign idelay_rst      = idelay_rst_reg;
   assign core_rst        = core_rst_reg;
   assign user_rst        = user_rst_reg;
   assign seq_done        = seq_done_reg;
   assign seq_fault       = seq_fault_reg;
   assign seq_state       = state_reg;
   assign retry_count     = retry_reg;
   assign lock_loss_count = loss_reg;

endmodule

// File: tb/tb_roach_reset_sequencer.sv
// Directed/randomized bench for roach_reset_sequencer. Expected behaviour is
// computed as event times from the sequencing rules (sync latency, filter
// length, pulse width, timeout, release gap) relative to stimulus cycles.
module tb_roach_reset_sequencer;

   localparam int LF  = 8;
   localparam int IRC = 4;
   localparam int TO  = 32;
   localparam int MR  = 2;
   localparam int RG  = 3;
   localparam int LOCK_LAT = 2 + LF;     // lock drive to idelay_rst rise
   localparam int PERIOD   = IRC + TO;   // idelay_rst rise to next rise on retry

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       mmcm_lock = 1'b0;
   logic       idelay_rdy = 1'b0;
   logic       idelay_rst, core_rst, user_rst, seq_done, seq_fault;
   logic [2:0] seq_state;
   logic [3:0] retry_count;
   logic [7:0] lock_loss_count;

   int cyc = 0;
   int n_assert = 0;
   int n_fail = 0;
   int rises[$];
   int high_cycles = 0;
   logic prev_idr = 1'b0;

   roach_reset_sequencer #(
      .LOCK_FILTER(LF), .IDELAY_RST_CYCLES(IRC), .RDY_TIMEOUT(TO),
      .MAX_RETRY(MR), .RELEASE_GAP(RG)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .mmcm_lock(mmcm_lock), .idelay_rdy(idelay_rdy),
      .idelay_rst(idelay_rst), .core_rst(core_rst), .user_rst(user_rst),
      .seq_done(seq_done), .seq_fault(seq_fault), .seq_state(seq_state),
      .retry_count(retry_count), .lock_loss_count(lock_loss_count)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // Pulse recorder for idelay_rst: rise cycles and total high cycles.
   always @(negedge sys_clk) begin
      if (idelay_rst === 1'b1 && prev_idr !== 1'b1) rises.push_back(cyc);
      if (idelay_rst === 1'b1) high_cycles = high_cycles + 1;
      prev_idr = idelay_rst;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic goto(input int c);
      while (cyc < c) tick(1);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_idelay_rst"}, idelay_rst, 0);
      chk({tag, "_core_rst"}, core_rst, 1);
      chk({tag, "_user_rst"}, user_rst, 1);
      chk({tag, "_seq_done"}, seq_done, 0);
      chk({tag, "_seq_fault"}, seq_fault, 0);
      chk({tag, "_seq_state"}, seq_state, 0);
      chk({tag, "_retry"}, retry_count, 0);
      chk({tag, "_loss"}, lock_loss_count, 0);
   endtask

   initial begin
      int L, L2, W, W2, R, R1, F, k, h, o, P, g0, g1;

      // ---- reset ----
      sys_rst = 1'b1;
      tick(3);
      chk_reset("reset");
      sys_rst = 1'b0;
      tick(2);
      chk("idle_state", seq_state, 0);

      // ---- nominal ----
      rises.delete();
      high_cycles = 0;
      L = cyc; mmcm_lock = 1'b1;
      goto(L + LOCK_LAT - 1);
      chk("nom_idr_before", idelay_rst, 0);
      chk("nom_state_before", seq_state, 0);
      goto(L + LOCK_LAT);
      chk("nom_idr_rise", idelay_rst, 1);
      chk("nom_state_idly", seq_state, 1);
      goto(L + LOCK_LAT + IRC - 1);
      chk("nom_idr_last", idelay_rst, 1);
      W = L + LOCK_LAT + IRC;
      goto(W);
      chk("nom_idr_fall", idelay_rst, 0);
      chk("nom_state_wait", seq_state, 2);
      goto(W + 10);
      R = cyc; idelay_rdy = 1'b1;
      goto(R + 2);
      chk("nom_core_held", core_rst, 1);
      goto(R + 3);
      chk("nom_core_fall", core_rst, 0);
      chk("nom_user_held", user_rst, 1);
      chk("nom_state_rel", seq_state, 3);
      goto(R + 2 + RG);
      chk("nom_user_gap", user_rst, 1);
      chk("nom_done_gap", seq_done, 0);
      goto(R + 3 + RG);
      chk("nom_user_fall", user_rst, 0);
      chk("nom_done", seq_done, 1);
      chk("nom_state_run", seq_state, 4);
      chk("nom_retry", retry_count, 0);
      chk("nom_fault", seq_fault, 0);
      tick(1);
      chk("nom_pulses", rises.size(), 1);
      chk("nom_pulse_width", high_cycles, IRC);

      // ---- lock loss in RUN, three times (rdy stays high) ----
      for (int i = 0; i < 3; i++) begin
         tick($urandom_range(2, 6));
         F = cyc; mmcm_lock = 1'b0;
         k = $urandom_range(3, 8);
         goto(F + 2);
         chk("loss_still_run", seq_state, 4);
         goto(F + 3);
         chk("loss_core_rst", core_rst, 1);
         chk("loss_user_rst", user_rst, 1);
         chk("loss_done", seq_done, 0);
         chk("loss_idr", idelay_rst, 0);
         chk("loss_state", seq_state, 0);
         chk("loss_count", lock_loss_count, i + 1);
         goto(F + k);
         L = cyc; mmcm_lock = 1'b1;
         goto(L + LOCK_LAT);
         chk("reacq_idr_rise", idelay_rst, 1);
         W = L + LOCK_LAT + IRC;
         goto(W + 1);
         chk("reacq_core_fall", core_rst, 0);
         goto(W + RG);
         chk("reacq_done_gap", seq_done, 0);
         goto(W + 1 + RG);
         chk("reacq_done", seq_done, 1);
         chk("reacq_state", seq_state, 4);
      end
      chk("loss_total", lock_loss_count, 3);

      // ---- rdy coincident with timeout, then sys_rst mid-REL_CORE ----
      mmcm_lock = 1'b0; idelay_rdy = 1'b0;
      tick(6);
      chk("sim_state_wl", seq_state, 0);
      chk("sim_loss4", lock_loss_count, 4);
      L = cyc; mmcm_lock = 1'b1;
      W = L + LOCK_LAT + IRC;
      goto(W);
      chk("sim_state_wait", seq_state, 2);
      goto(W + TO - 3);
      idelay_rdy = 1'b1;          // rdy_s first seen on the timeout edge
      goto(W + TO - 1);
      chk("sim_state_pre", seq_state, 2);
      goto(W + TO);
      chk("sim_state_rel", seq_state, 3);
      chk("sim_core_fall", core_rst, 0);
      chk("sim_retry", retry_count, 0);
      chk("sim_idr", idelay_rst, 0);
      goto(W + TO + 1);
      sys_rst = 1'b1; mmcm_lock = 1'b0; idelay_rdy = 1'b0;
      tick(1);
      chk_reset("rst_mid_rel");
      tick(2);
      sys_rst = 1'b0;
      tick(2);

      // ---- lock glitch, then retry exhaustion into FAULT ----
      rises.delete();
      high_cycles = 0;
      h = $urandom_range(1, LF - 1);
      mmcm_lock = 1'b1;
      tick(h);
      mmcm_lock = 1'b0;
      tick(1);
      L2 = cyc; mmcm_lock = 1'b1;
      while (cyc < L2 + LOCK_LAT - 1) begin
         chk("glitch_no_early", idelay_rst, 0);
         tick(1);
      end
      chk("glitch_idr_pre", idelay_rst, 0);
      goto(L2 + LOCK_LAT);
      chk("glitch_idr_rise", idelay_rst, 1);
      R1 = cyc;
      goto(R1 + PERIOD);
      chk("retry1_idr", idelay_rst, 1);
      chk("retry1_count", retry_count, 1);
      goto(R1 + 2 * PERIOD);
      chk("retry2_idr", idelay_rst, 1);
      chk("retry2_count", retry_count, 2);
      goto(R1 + 2 * PERIOD + IRC + TO - 1);
      chk("fault_pre", seq_fault, 0);
      chk("fault_pre_state", seq_state, 2);
      goto(R1 + 2 * PERIOD + IRC + TO);
      chk("fault_flag", seq_fault, 1);
      chk("fault_state", seq_state, 5);
      chk("fault_retry", retry_count, 2);
      chk("fault_core", core_rst, 1);
      chk("fault_user", user_rst, 1);
      tick(1);
      chk("fault_pulses", rises.size(), 3);
      chk("fault_pulse_cycles", high_cycles, 3 * IRC);
      g0 = (rises.size() == 3) ? rises[1] - rises[0] : -1;
      g1 = (rises.size() == 3) ? rises[2] - rises[1] : -1;
      chk("fault_gap0", g0, PERIOD);
      chk("fault_gap1", g1, PERIOD);
      for (int i = 0; i < 3; i++) begin
         mmcm_lock = 1'b0;
         tick(3 + i);
         chk("fault_sticky_low", seq_state, 5);
         mmcm_lock = 1'b1;
         tick(LF + 4);
         chk("fault_sticky_high", seq_state, 5);
         chk("fault_sticky_flag", seq_fault, 1);
         chk("fault_sticky_idr", idelay_rst, 0);
      end
      sys_rst = 1'b1; mmcm_lock = 1'b0;
      tick(1);
      chk_reset("fault_cleared");
      tick(1);
      sys_rst = 1'b0;
      tick(2);

      // ---- late rdy during the second WAIT_RDY ----
      rises.delete();
      high_cycles = 0;
      L = cyc; mmcm_lock = 1'b1;
      R1 = L + LOCK_LAT;
      W2 = R1 + PERIOD + IRC;
      o = $urandom_range(0, TO - 4);
      goto(W2 + o);
      P = cyc; idelay_rdy = 1'b1;
      goto(P + 3);
      chk("late_state_rel", seq_state, 3);
      chk("late_retry", retry_count, 1);
      chk("late_core_fall", core_rst, 0);
      goto(P + 3 + RG);
      chk("late_state_run", seq_state, 4);
      chk("late_done", seq_done, 1);
      chk("late_user", user_rst, 0);
      chk("late_retry_run", retry_count, 1);
      tick(1);
      chk("late_pulses", rises.size(), 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
